// File: rtl/bcd_counter.sv
// Two-digit BCD up-counter with prescaler and IDLE/RUN/PAUSE control.
// Optional feature macro: BCD_LOAD_EN adds a direct digit load port.
module bcd_counter #(
  parameter int         PRESCALE  = 50_000_000,
  parameter logic [3:0] MAX_TENS  = 4'd5,
  parameter logic [3:0] MAX_UNITS = 4'd9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
`ifdef BCD_LOAD_EN
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
`endif
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       tick,
  output logic       wrap,
  output logic       running
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] presc;
  logic          at_max;
  logic [3:0]    inc_tens;
  logic [3:0]    inc_units;
  logic          do_load;
  logic [3:0]    ld_tens;
  logic [3:0]    ld_units;

`ifdef BCD_LOAD_EN
  logic load_over;
  assign do_load   = load;
  assign load_over = (load_tens > 4'd9) || (load_units > 4'd9) ||
                     ({load_tens, load_units} > {MAX_TENS, MAX_UNITS});
  assign ld_tens   = load_over ? MAX_TENS  : load_tens;
  assign ld_units  = load_over ? MAX_UNITS : load_units;
`else
  assign do_load  = 1'b0;
  assign ld_tens  = 4'd0;
  assign ld_units = 4'd0;
`endif

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else if (do_load) begin
      state_next = state;
    end else if (stop && state == RUN) begin
      state_next = PAUSE;
    end else if (start && state != RUN) begin
      state_next = RUN;
    end
  end

  // Terminal value wraps straight to 00, which may happen before 99.
  always_comb begin
    at_max    = (tens == MAX_TENS) && (units == MAX_UNITS);
    inc_tens  = tens;
    inc_units = units + 4'd1;
    if (at_max) begin
      inc_tens  = 4'd0;
      inc_units = 4'd0;
    end else if (units == 4'd9) begin
      inc_tens  = tens + 4'd1;
      inc_units = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      tens  <= 4'd0;
      units <= 4'd0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (clear) begin
        presc <= '0;
        tens  <= 4'd0;
        units <= 4'd0;
      end else if (do_load) begin
        presc <= '0;
        tens  <= ld_tens;
        units <= ld_units;
      end else if (state == RUN) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          tens  <= inc_tens;
          units <= inc_units;
          tick  <= 1'b1;
          wrap  <= at_max;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter.sv
// Directed testbench for bcd_counter with PRESCALE=4 and terminal 5:9.
// Define BCD_LOAD_EN to also exercise the load port.
module tb_bcd_counter;

  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic       clear;
`ifdef BCD_LOAD_EN
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_units;
`endif
  logic [3:0] tens;
  logic [3:0] units;
  logic       tick;
  logic       wrap;
  logic       running;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_counter #(
    .PRESCALE (PRESCALE),
    .MAX_TENS (4'd5),
    .MAX_UNITS(4'd9)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
`ifdef BCD_LOAD_EN
    .load      (load),
    .load_tens (load_tens),
    .load_units(load_units),
`endif
    .tens      (tens),
    .units     (units),
    .tick      (tick),
    .wrap      (wrap),
    .running   (running)
  );

  // Observed outputs packed as {tens, units, tick, wrap, running}.
  function automatic logic [10:0] snap();
    return {tens, units, tick, wrap, running};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [10:0] exp;
    reset_n = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    clear   = 1'b0;
`ifdef BCD_LOAD_EN
    load       = 1'b0;
    load_tens  = 4'd0;
    load_units = 4'd0;
`endif
    #12;
    exp = 11'd0;
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h want %h", snap(), exp);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step(2);
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_count();
    logic [10:0] exp;
    start = 1'b1;
    step();
    start = 1'b0;
    exp = {4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL start_latency: got %h want %h", snap(), exp);
    end
    for (int n = 1; n <= 3; n++) begin
      step(3);
      exp = {4'd0, 4'(n - 1), 1'b0, 1'b0, 1'b1};
      checks++;
      if (snap() !== exp) begin
        errors++;
        $display("[TB] FAIL pre_tick_%0d: got %h want %h", n, snap(), exp);
      end
      step();
      exp = {4'd0, 4'(n), 1'b1, 1'b0, 1'b1};
      checks++;
      if (snap() !== exp) begin
        errors++;
        $display("[TB] FAIL tick_%0d: got %h want %h", n, snap(), exp);
      end
    end
  endtask

  task automatic test_carry();
    logic [10:0] exp;
    step(4 * 6);
    exp = {4'd0, 4'd9, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL reach_09: got %h want %h", snap(), exp);
    end
    step(4);
    exp = {4'd1, 4'd0, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL carry_10: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_wrap();
    logic [10:0] exp;
    step(4 * 49);
    exp = {4'd5, 4'd9, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL reach_59: got %h want %h", snap(), exp);
    end
    step(4);
    exp = {4'd0, 4'd0, 1'b1, 1'b1, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL wrap_00: got %h want %h", snap(), exp);
    end
    step();
    exp = {4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL wrap_pulse_width: got %h want %h", snap(), exp);
    end
    step(3);
    exp = {4'd0, 4'd1, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL after_wrap_01: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_pause();
    logic [10:0] exp;
    int ticks_seen;
    step(4 * 22);
    exp = {4'd2, 4'd3, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL reach_23: got %h want %h", snap(), exp);
    end
    // The stop edge is still a RUN edge, so the prescaler advances to 1 and then holds.
    stop = 1'b1;
    step();
    stop = 1'b0;
    ticks_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick) ticks_seen++;
    end
    checks++;
    if (ticks_seen !== 0) begin
      errors++;
      $display("[TB] FAIL pause_ticks: got %0d want 0", ticks_seen);
    end
    exp = {4'd2, 4'd3, 1'b0, 1'b0, 1'b0};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL pause_hold: got %h want %h", snap(), exp);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step(2);
    exp = {4'd2, 4'd3, 1'b0, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL resume_pre_tick: got %h want %h", snap(), exp);
    end
    step();
    exp = {4'd2, 4'd4, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL resume_held_presc: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_stop_wins();
    logic [10:0] exp;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    exp = {4'd2, 4'd4, 1'b0, 1'b0, 1'b0};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL stop_over_start: got %h want %h", snap(), exp);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step(3);
    exp = {4'd2, 4'd5, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL restart_25: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_clear();
    logic [10:0] exp;
    step(4 * 22);
    exp = {4'd4, 4'd7, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL reach_47: got %h want %h", snap(), exp);
    end
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    exp = 11'd0;
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL clear_over_start: got %h want %h", snap(), exp);
    end
    step(6);
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL clear_stays_idle: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] exp;
    start = 1'b1;
    step();
    start = 1'b0;
    step(4 * 5 + 2);
    exp = {4'd0, 4'd5, 1'b0, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL mid_prescale_05: got %h want %h", snap(), exp);
    end
    #3 reset_n = 1'b0;
    #1;
    exp = 11'd0;
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h want %h", snap(), exp);
    end
    #2 reset_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step(3);
    exp = {4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL presc_zeroed_by_reset: got %h want %h", snap(), exp);
    end
    step();
    exp = {4'd0, 4'd1, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL first_tick_after_reset: got %h want %h", snap(), exp);
    end
  endtask

`ifdef BCD_LOAD_EN
  task automatic test_load();
    logic [10:0] exp;
    load       = 1'b1;
    load_tens  = 4'd3;
    load_units = 4'd1;
    step();
    exp = {4'd3, 4'd1, 1'b0, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL load_31: got %h want %h", snap(), exp);
    end
    load_tens  = 4'd9;
    load_units = 4'd9;
    step();
    exp = {4'd5, 4'd9, 1'b0, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL load_99_saturate: got %h want %h", snap(), exp);
    end
    load_tens  = 4'd6;
    load_units = 4'd0;
    step();
    load = 1'b0;
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL load_60_saturate: got %h want %h", snap(), exp);
    end
    step(4);
    exp = {4'd0, 4'd0, 1'b1, 1'b1, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("[TB] FAIL wrap_after_load: got %h want %h", snap(), exp);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_count();
    test_carry();
    test_wrap();
    test_pause();
    test_stop_wins();
    test_clear();
    test_async_reset();
`ifdef BCD_LOAD_EN
    test_load();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
